serial_magnitude_compare: RTL and testbench
===========================================

Name: serial_magnitude_compare

Overview:
Parametrised, bit-serial magnitude comparator and the sequential successor to the team's combinational greater-than block. Operands are latched on a start handshake and compared MSB-first, one bit per clock, terminating early at the first differing bit. The block reports gt/eq/lt for both unsigned and two's-complement operands. It serves area-constrained datapaths where wide combinational comparators are not affordable.

Parameters:
NUM_BITS, 4, operand width in bits; legal range >= 1.
CNT_W, $clog2(NUM_BITS+1), width of bits_examined; derived, not to be overridden.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request a comparison; sampled only when busy=0.
a  input  NUM_BITS  operand A; sampled on accepted start.
b  input  NUM_BITS  operand B; sampled on accepted start.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accepted start.
busy  output  1  comparison in progress.
done  output  1  one-cycle pulse; results valid and updated this cycle.
gt  output  1  A > B for the last completed compare.
eq  output  1  A == B for the last completed compare.
lt  output  1  A < B for the last completed compare.
bits_examined  output  CNT_W  number of bit positions examined in the last completed compare (1..NUM_BITS).

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; busy=0, done=0, gt=eq=lt=0, bits_examined=0. Reset overrides all other inputs.
- States: IDLE, COMPARE. done is a registered pulse, not a separate state.
- IDLE: start=1 at edge E0 latches a, b and signed_mode, sets index = NUM_BITS-1, and moves to COMPARE. busy=1 from E0.
- COMPARE, one edge per bit. Evaluate a_lat[index] vs b_lat[index]:
  - Bits differ, unsigned (or signed at index < NUM_BITS-1): gt = a_bit, lt = b_bit.
  - Bits differ, signed at index NUM_BITS-1: result inverted (gt = b_bit, lt = a_bit).
  - Bits differ: eq=0, done=1, busy=0, bits_examined = NUM_BITS-index, next state IDLE.
  - Bits equal, index==0: eq=1, gt=lt=0, done=1, busy=0, bits_examined = NUM_BITS, next state IDLE.
  - Bits equal, index>0: decrement index and stay in COMPARE.
- Latency: done is high in the cycle after edge E_m, where m = bits_examined. Minimum m=1, maximum m=NUM_BITS.
- done is high for exactly one cycle per accepted start.
- After the first completion, exactly one of gt/eq/lt is 1. Results and bits_examined hold until the next completion or reset.
- start while busy=1 is ignored; the operation in flight is unaffected. Inputs a, b and signed_mode may change freely while busy.
- A start in the done cycle (busy=0) is accepted. Back-to-back throughput is therefore m+1 cycles per compare.
- Reset mid-operation aborts the compare: no done pulse, and outputs return to reset values.
- NUM_BITS=1, signed: the single bit is the sign bit (1 = -1). a=1, b=0 gives lt.

Test Plan:
- Reset with NUM_BITS=4: hold rst_n=0 for 3 cycles, with start=1 throughout. Required: busy=done=gt=eq=lt=0 and bits_examined=0 for the entire reset.
- Unsigned, a=9, b=3, start pulse. Required: done one cycle after the start edge plus one compare edge, gt=1, bits_examined=1. Repeat with signed_mode=1 (-7 vs 3): lt=1, bits_examined=1.
- a=5, b=5, unsigned. Required: busy for 4 compare cycles, then eq=1, bits_examined=4. Then a=6, b=7: lt=1 at bit 0, bits_examined=4.
- Hold start=1 continuously with a=12, b=4. Required: a new compare is accepted in each done cycle, done pulses every 2 cycles, and gt=1 each time. Changing a, b or signed_mode mid-compare does not alter the result.
- Start a=0, b=0. Assert rst_n=0 after 2 compare cycles. Required: no done pulse, all outputs cleared. After release, the next start (a=2, b=1) completes normally with gt=1.
- Exhaustive sweep, all 16x16 pairs in both modes. Required: gt/eq/lt match a behavioural compare, and bits_examined = NUM_BITS minus the index of the highest differing bit (4 when equal).

Source files
------------

// File: rtl/serial_magnitude_compare.sv
// Bit-serial magnitude comparator.
// Operands are captured on an accepted start and examined MSB-first, one bit
// per clock. The first differing bit decides the result, so a compare takes
// between 1 and NUM_BITS compare cycles. Unsigned and two's-complement
// orderings are supported; in signed mode a difference in the sign bit
// reverses the ordering. All outputs come straight from registers.
`timescale 1ns/1ps

module serial_magnitude_compare #(
    parameter int NUM_BITS = 4,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CNT_W-1:0] bits_examined
);

    // Index width; a 1-bit operand still needs a 1-bit index register.
    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(NUM_BITS - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BITS);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COMPARE = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [NUM_BITS-1:0] a_lat_r;
    logic [NUM_BITS-1:0] b_lat_r;
    logic                signed_lat_r;
    logic [IDX_W-1:0]    idx_r;

    logic                a_bit_s;
    logic                b_bit_s;
    logic                diff_s;
    logic                sign_pos_s;
    logic [1:0]          order_s;

    logic                busy_r;
    logic                done_r;
    logic                gt_r;
    logic                eq_r;
    logic                lt_r;
    logic [CNT_W-1:0]    bits_r;

    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                gt_nxt_s;
    logic                eq_nxt_s;
    logic                lt_nxt_s;
    logic [CNT_W-1:0]    bits_nxt_s;

    // Ordering decided by one differing bit pair, returned as {gt, lt}.
    // At the sign position of a signed compare a set bit means the smaller
    // value, so the ordering flips.
    function automatic logic [1:0] bit_order(
        input logic a_bit,
        input logic b_bit,
        input logic invert
    );
        logic [1:0] res;
        if (invert) begin
            res = {b_bit, a_bit};
        end else begin
            res = {a_bit, b_bit};
        end
        return res;
    endfunction

    assign a_bit_s    = a_lat_r[idx_r];
    assign b_bit_s    = b_lat_r[idx_r];
    assign diff_s     = a_bit_s ^ b_bit_s;
    assign sign_pos_s = signed_lat_r & (idx_r == MSB_IDX);
    assign order_s    = bit_order(a_bit_s, b_bit_s, sign_pos_s);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture on accepted start and MSB-to-LSB index walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_lat_r      <= {NUM_BITS{1'b0}};
            b_lat_r      <= {NUM_BITS{1'b0}};
            signed_lat_r <= 1'b0;
            idx_r        <= ZERO_IDX;
        end else if ((state_r == ST_IDLE) && start) begin
            a_lat_r      <= a;
            b_lat_r      <= b;
            signed_lat_r <= signed_mode;
            idx_r        <= MSB_IDX;
        end else if ((state_r == ST_COMPARE) && !diff_s && (idx_r != ZERO_IDX)) begin
            idx_r        <= idx_r - IDX_W'(1);
        end else begin
            idx_r        <= idx_r;
        end
    end

    // Next-state: leave COMPARE on the first differing bit or after bit 0.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_COMPARE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                if (diff_s || (idx_r == ZERO_IDX)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COMPARE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; results hold between completions.
    always_comb begin
        busy_nxt_s = busy_r;
        done_nxt_s = 1'b0;
        gt_nxt_s   = gt_r;
        eq_nxt_s   = eq_r;
        lt_nxt_s   = lt_r;
        bits_nxt_s = bits_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    busy_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_COMPARE: begin
                if (diff_s) begin
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b1;
                    gt_nxt_s   = order_s[1];
                    lt_nxt_s   = order_s[0];
                    eq_nxt_s   = 1'b0;
                    bits_nxt_s = FULL_CNT - CNT_W'(idx_r);
                end else if (idx_r == ZERO_IDX) begin
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b1;
                    gt_nxt_s   = 1'b0;
                    lt_nxt_s   = 1'b0;
                    eq_nxt_s   = 1'b1;
                    bits_nxt_s = FULL_CNT;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            gt_r   <= 1'b0;
            eq_r   <= 1'b0;
            lt_r   <= 1'b0;
            bits_r <= {CNT_W{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            gt_r   <= gt_nxt_s;
            eq_r   <= eq_nxt_s;
            lt_r   <= lt_nxt_s;
            bits_r <= bits_nxt_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign gt            = gt_r;
    assign eq            = eq_r;
    assign lt            = lt_r;
    assign bits_examined = bits_r;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Self-checking bench for serial_magnitude_compare (NUM_BITS = 4).
// Expected results come from an arithmetic reference: operands are turned
// into integers (sign-extended in signed mode) and compared directly; the
// examined-bit count is derived from the highest set bit of a ^ b.
`timescale 1ns/1ps

module tb_serial_magnitude_compare;

    localparam int NB = 4;
    localparam int CW = $clog2(NB + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          signed_mode;
    logic          busy;
    logic          done;
    logic          gt;
    logic          eq;
    logic          lt;
    logic [CW-1:0] bits_examined;

    int checks = 0;
    int errors = 0;

    serial_magnitude_compare #(.NUM_BITS(NB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .signed_mode   (signed_mode),
        .busy          (busy),
        .done          (done),
        .gt            (gt),
        .eq            (eq),
        .lt            (lt),
        .bits_examined (bits_examined)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference compare: plain integer arithmetic on the operand values.
    task automatic ref_cmp(input int av, input int bv, input bit sm,
                           output logic eg, output logic ee, output logic el,
                           output int em);
        int  va;
        int  vb;
        int  x;
        bit  found;
        va = av;
        vb = bv;
        if (sm) begin
            if (av >= (1 << (NB - 1))) va = av - (1 << NB);
            if (bv >= (1 << (NB - 1))) vb = bv - (1 << NB);
        end
        eg = (va > vb);
        ee = (va == vb);
        el = (va < vb);
        x  = av ^ bv;
        em = NB;
        found = 1'b0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (!found && (((x >> i) & 1) == 1)) begin
                em = NB - i;
                found = 1'b1;
            end
        end
    endtask

    // One full compare, entered and left at a falling edge. Inputs are
    // scrambled while busy to show they do not affect the compare in flight.
    task automatic run_cmp(input int av, input int bv, input bit sm, input string tag);
        logic eg, ee, el;
        int   em;
        int   k;
        ref_cmp(av, bv, sm, eg, ee, el, em);
        a = NB'(av);
        b = NB'(bv);
        signed_mode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            a = NB'($urandom);
            b = NB'($urandom);
            signed_mode = 1'($urandom);
        end while (done !== 1'b1 && k < 12);
        chk({tag, "_done"}, 32'(done), 32'(1));
        chk({tag, "_lat"}, 32'(k), 32'(em));
        chk({tag, "_res"}, 32'({busy, gt, eq, lt}), 32'({1'b0, eg, ee, el}));
        chk({tag, "_bits"}, 32'(bits_examined), 32'(em));
        @(negedge clk);
        chk({tag, "_hold"}, 32'({done, gt, eq, lt, bits_examined}),
            32'({1'b0, eg, ee, el, CW'(em)}));
    endtask

    initial begin
        int dones;
        int last_done;
        rst_n = 1'b0;
        start = 1'b1;
        a = 4'd9;
        b = 4'd3;
        signed_mode = 1'b0;

        // Reset held 3 cycles with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", 32'({busy, done, gt, eq, lt, bits_examined}), 32'(0));
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_cmp(9, 3, 1'b0, "u9v3");
        run_cmp(9, 3, 1'b1, "s9v3");
        run_cmp(5, 5, 1'b0, "u5v5");
        run_cmp(6, 7, 1'b0, "u6v7");
        run_cmp(8, 7, 1'b1, "s8v7");
        run_cmp(15, 0, 1'b1, "s15v0");

        // Start held high: one compare accepted in every done cycle.
        a = 4'd12;
        b = 4'd4;
        signed_mode = 1'b0;
        start = 1'b1;
        dones = 0;
        last_done = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                chk("b2b_res", 32'({gt, eq, lt, bits_examined}), 32'({3'b100, CW'(1)}));
                if (last_done >= 0) chk("b2b_gap", 32'(i - last_done), 32'(2));
                last_done = i;
                a = 4'd12;
                b = 4'd4;
                signed_mode = 1'b0;
            end else begin
                chk("b2b_busy", 32'(busy), 32'(1));
                a = NB'($urandom);
                b = NB'($urandom);
                signed_mode = 1'b1;
            end
        end
        chk("b2b_count", 32'(dones), 32'(4));
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset during a compare aborts it.
        a = 4'd0;
        b = 4'd0;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'({busy, done}), 32'(2));
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_rst", 32'({busy, done, gt, eq, lt, bits_examined}), 32'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'({busy, done}), 32'(0));
        run_cmp(2, 1, 1'b0, "post_rst");

        // Exhaustive sweep over both modes.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_cmp(x, y, m[0], "sweep");
                end
            end
        end

        // Random compares.
        for (int i = 0; i < 40; i++) begin
            run_cmp(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                    1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
